expr_eval: RTL

EXPR_EVAL -- requirements
Module: expr_eval

---
 rtl/expr_pkg.sv | 29 ++
 rtl/expr_char_class.sv | 32 +++
 rtl/expr_eval.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/expr_pkg.sv
// Shared types and constants for the streaming expression evaluator.
//   state_e      : evaluator FSM states
//   char_class_e : classification of an input character
//   ASCII_*      : character codes recognised by the classifier
// Optional feature macro: EXPR_EVAL_MINUS_EN (enables binary '-').
package expr_pkg;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_NUM,
      S_OP,
      S_ERR
   } state_e;

   typedef enum logic [2:0] {
      DIGIT,
      ADD,
      MUL,
      SUB,
      BAD
   } char_class_e;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_STAR  = 8'h2A;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier.
// Ports:
//   char_i  [7:0] : ASCII character
//   cls_o         : character class (DIGIT, ADD, MUL, SUB, BAD)
//   digit_o [3:0] : numeric value of a digit, zero otherwise
// Macro EXPR_EVAL_MINUS_EN: when undefined '-' is classified BAD.
module expr_char_class
   import expr_pkg::*;
(
   input  logic [7:0]  char_i,
   output char_class_e cls_o,
   output logic [3:0]  digit_o
);

   always_comb begin
      cls_o   = BAD;
      digit_o = 4'd0;
      if (char_i >= ASCII_0 && char_i <= ASCII_9) begin
         cls_o   = DIGIT;
         digit_o = 4'(char_i - ASCII_0);
      end else if (char_i == ASCII_PLUS) begin
         cls_o = ADD;
      end else if (char_i == ASCII_STAR) begin
         cls_o = MUL;
`ifdef EXPR_EVAL_MINUS_EN
      end else if (char_i == ASCII_MINUS) begin
         cls_o = SUB;
`endif
      end
   end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for "number (op number)*" with '*' binding tighter than '+'/'-'.
// Ports:
//   clk         : clock, rising edge
//   clr         : synchronous active-high reset, wins over vld
//   vld         : character strobe
//   in    [7:0] : ASCII character, consumed only when vld=1
//   out         : registered, high while the accepted string is a complete expression
//   err         : registered, sticky after an illegal character or sequence
//   value [W-1:0] : registered result of the expression so far (mod 2^W)
// Macro EXPR_EVAL_MINUS_EN: accept '-' as a binary operator; otherwise '-' is illegal and
// the sign register does not exist.
module expr_eval
   import expr_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         vld,
   input  logic [7:0]   in,
   output logic         out,
   output logic         err,
   output logic [W-1:0] value
);

   char_class_e cls;
   logic [3:0]  digit;

   expr_char_class u_char_class (
      .char_i  (in),
      .cls_o   (cls),
      .digit_o (digit)
   );

   state_e       state_q, state_d;
   logic [W-1:0] sum_q, sum_d;
   logic [W-1:0] prod_q, prod_d;
   logic [W-1:0] num_q, num_d;
   logic [W-1:0] value_q, value_d;
   logic         out_q, out_d;
   logic         err_q, err_d;
`ifdef EXPR_EVAL_MINUS_EN
   // High means the pending term is subtracted.
   logic         sign_q, sign_d;
`endif

   logic [W-1:0] num_nxt;
   logic [W-1:0] term_nxt;   // pending term including the incoming digit
   logic [W-1:0] term_cur;   // pending term as already accumulated
   logic [W-1:0] value_nxt;
   logic [W-1:0] sum_nxt;

   always_comb begin
      num_nxt  = num_q * W'(10) + W'(digit);
      term_nxt = prod_q * num_nxt;
      term_cur = prod_q * num_q;
`ifdef EXPR_EVAL_MINUS_EN
      value_nxt = sign_q ? (sum_q - term_nxt) : (sum_q + term_nxt);
      sum_nxt   = sign_q ? (sum_q - term_cur) : (sum_q + term_cur);
`else
      value_nxt = sum_q + term_nxt;
      sum_nxt   = sum_q + term_cur;
`endif
   end

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      prod_d  = prod_q;
      num_d   = num_q;
      value_d = value_q;
`ifdef EXPR_EVAL_MINUS_EN
      sign_d  = sign_q;
`endif
      if (vld) begin
         case (state_q)
            S_EMPTY, S_OP: begin
               if (cls == DIGIT) begin
                  state_d = S_NUM;
                  num_d   = num_nxt;
                  value_d = value_nxt;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_NUM: begin
               case (cls)
                  DIGIT: begin
                     num_d   = num_nxt;
                     value_d = value_nxt;
                  end
                  MUL: begin
                     state_d = S_OP;
                     prod_d  = term_cur;
                     num_d   = '0;
                  end
                  ADD: begin
                     state_d = S_OP;
                     sum_d   = sum_nxt;
                     prod_d  = W'(1);
                     num_d   = '0;
`ifdef EXPR_EVAL_MINUS_EN
                     sign_d  = 1'b0;
`endif
                  end
`ifdef EXPR_EVAL_MINUS_EN
                  SUB: begin
                     state_d = S_OP;
                     sum_d   = sum_nxt;
                     prod_d  = W'(1);
                     num_d   = '0;
                     sign_d  = 1'b1;
                  end
`endif
                  default: state_d = S_ERR;
               endcase
            end
            default: state_d = S_ERR;  // S_ERR is absorbing until clr
         endcase
      end
      out_d = (state_d == S_NUM);
      err_d = (state_d == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_EMPTY;
         sum_q   <= '0;
         prod_q  <= W'(1);
         num_q   <= '0;
         value_q <= '0;
         out_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef EXPR_EVAL_MINUS_EN
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         prod_q  <= prod_d;
         num_q   <= num_d;
         value_q <= value_d;
         out_q   <= out_d;
         err_q   <= err_d;
`ifdef EXPR_EVAL_MINUS_EN
         sign_q  <= sign_d;
`endif
      end
   end

   assign out   = out_q;
   assign err   = err_q;
   assign value = value_q;

endmodule
